rf_writeback: RTL and testbench

RF_WRITEBACK -- requirements
Module: rf_writeback

---
 rtl/rf_writeback.sv | 170 +++++++++++++++++
 tb/tb_rf_writeback.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback.sv
// Register-file writeback queue: merges ALU results (priority, no backpressure) and
// load results into one FIFO that drains into a single register-file write port.
module rf_writeback #(
   parameter int pw    = 3,
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_valid,
   input  logic [pw-1:0]     alu_addr,
   input  logic [7:0]        alu_dat,
   input  logic              zeroIn,
   input  logic              ngtvIn,
   input  logic              scryIn,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [pw-1:0]     ld_addr,
   input  logic [7:0]        ld_dat,
   input  logic              wr_stall,
   output logic              wr_en,
   output logic [pw-1:0]     wr_addr,
   output logic [7:0]        dat_out,
   output logic              zeroOut,
   output logic              ngtvOut,
   output logic              scryOut,
   output logic [2**pw-1:0]  pend,
   output logic              full,
   output logic              empty,
   output logic              ovf_err
);

   localparam int AW   = $clog2(DEPTH);
   localparam int NREG = 2**pw;

   typedef struct packed {
      logic [pw-1:0] addr;
      logic [7:0]    dat;
      logic [2:0]    flg;     // {zero, negative, carry}
      logic          is_alu;
   } entry_t;

   entry_t           mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             wr_en_q, wr_en_d;
   logic [pw-1:0]    wr_addr_q, wr_addr_d;
   logic [7:0]       dat_out_q, dat_out_d;
   logic [2:0]       flg_q, flg_d;
   logic [2:0]       shd_q, shd_d;
   logic             ovf_q, ovf_d;

   logic             pop, push, push_alu, push_ld, full_eff;
   entry_t           head, push_entry;
   logic [DEPTH-1:0] occ;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign pop   = !empty && !wr_stall;

   // A pop in the same cycle frees a slot, so the queue only blocks when not draining.
   assign full_eff = full && !pop;
   assign ld_ready = !alu_valid && !full_eff;
   assign push_alu = alu_valid && !full_eff;
   assign push_ld  = ld_valid && ld_ready;
   assign push     = push_alu || push_ld;
   assign head     = mem_q[rd_ptr_q];

   always_comb begin
      push_entry = '0;
      if (alu_valid) begin
         push_entry.addr   = alu_addr;
         push_entry.dat    = alu_dat;
         push_entry.flg    = {zeroIn, ngtvIn, scryIn};
         push_entry.is_alu = 1'b1;
      end else begin
         push_entry.addr   = ld_addr;
         push_entry.dat    = ld_dat;
      end
   end

   // Storage carries no reset: occupancy is defined purely by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_entry;
   end

   always_comb begin
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      wr_en_d   = pop;
      wr_addr_d = wr_addr_q;
      dat_out_d = dat_out_q;
      flg_d     = flg_q;
      shd_d     = shd_q;
      ovf_d     = ovf_q | (alu_valid && full_eff);

      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase

      if (pop) begin
         wr_addr_d = head.addr;
         dat_out_d = head.dat;
         if (head.is_alu) begin
            flg_d = head.flg;
            shd_d = head.flg;
         end else begin
            flg_d = shd_q;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         dat_out_q <= '0;
         flg_q     <= '0;
         shd_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         dat_out_q <= dat_out_d;
         flg_q     <= flg_d;
         shd_q     <= shd_d;
         ovf_q     <= ovf_d;
      end
   end

   // Slot gi is occupied when its distance from the head is below the count.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_occ
         logic [AW-1:0] offs;
         assign offs    = AW'(gi) - rd_ptr_q;
         assign occ[gi] = ({1'b0, offs} < count_q);
      end
   endgenerate

   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (occ[i]) pend[mem_q[i].addr] = 1'b1;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign dat_out = dat_out_q;
   assign zeroOut = flg_q[2];
   assign ngtvOut = flg_q[1];
   assign scryOut = flg_q[0];
   assign ovf_err = ovf_q;

   logic unused_nreg;
   assign unused_nreg = (NREG == 0);

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: expected writes go into a scoreboard queue when
// driven and are popped and compared whenever the DUT raises wr_en.
module tb_rf_writeback;

   localparam int PW    = 3;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          alu_valid;
   logic [PW-1:0] alu_addr;
   logic [7:0]    alu_dat;
   logic          zeroIn, ngtvIn, scryIn;
   logic          ld_valid;
   logic          ld_ready;
   logic [PW-1:0] ld_addr;
   logic [7:0]    ld_dat;
   logic          wr_stall;
   logic          wr_en;
   logic [PW-1:0] wr_addr;
   logic [7:0]    dat_out;
   logic          zeroOut, ngtvOut, scryOut;
   logic [7:0]    pend;
   logic          full, empty, ovf_err;

   typedef struct {
      logic [PW-1:0] a;
      logic [7:0]    d;
      logic [2:0]    f;
   } exp_t;

   exp_t       sb[$];
   logic [2:0] sh;
   int         ncmp = 0;
   int         nfail = 0;
   int         nwr = 0;
   int         wr_mark;

   rf_writeback #(.pw(PW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_dat(alu_dat),
      .zeroIn(zeroIn), .ngtvIn(ngtvIn), .scryIn(scryIn),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_dat(ld_dat),
      .wr_stall(wr_stall), .wr_en(wr_en), .wr_addr(wr_addr), .dat_out(dat_out),
      .zeroOut(zeroOut), .ngtvOut(ngtvOut), .scryOut(scryOut),
      .pend(pend), .full(full), .empty(empty), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      ncmp++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (wr_en === 1'b1) begin
         nwr++;
         if (sb.size() == 0) begin
            chk("unexpected_wr", {31'b0, wr_en}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("wr_addr", {29'b0, wr_addr}, {29'b0, e.a});
            chk("dat_out", {24'b0, dat_out}, {24'b0, e.d});
            chk("flags", {29'b0, zeroOut, ngtvOut, scryOut}, {29'b0, e.f});
            $display("write addr=%0d data=%02h flags=%03b", wr_addr, dat_out,
                     {zeroOut, ngtvOut, scryOut});
         end
      end
   endtask

   task automatic idle();
      alu_valid = 1'b0; alu_addr = '0; alu_dat = '0;
      zeroIn = 1'b0; ngtvIn = 1'b0; scryIn = 1'b0;
      ld_valid = 1'b0; ld_addr = '0; ld_dat = '0;
   endtask

   task automatic drive_alu(input logic [PW-1:0] a, input logic [7:0] d,
                            input logic [2:0] f, input bit accept);
      exp_t e;
      alu_valid = 1'b1; alu_addr = a; alu_dat = d;
      {zeroIn, ngtvIn, scryIn} = f;
      if (accept) begin
         e.a = a; e.d = d; e.f = f;
         sb.push_back(e);
         sh = f;
      end
   endtask

   task automatic drive_ld(input logic [PW-1:0] a, input logic [7:0] d);
      exp_t e;
      ld_valid = 1'b1; ld_addr = a; ld_dat = d;
      e.a = a; e.d = d; e.f = sh;
      sb.push_back(e);
   endtask

   task automatic drain(input int max_cycles);
      for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick();
      chk("drain_left", sb.size(), 32'd0);
      chk("drain_empty", {31'b0, empty}, 32'd1);
   endtask

   initial begin
      sh = 3'b000;
      reset = 1'b0;
      wr_stall = 1'b0;
      idle();
      #2;
      chk("rst_empty", {31'b0, empty}, 32'd1);
      chk("rst_full", {31'b0, full}, 32'd0);
      chk("rst_pend", {24'b0, pend}, 32'd0);
      chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
      chk("rst_ovf", {31'b0, ovf_err}, 32'd0);
      chk("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // single ALU write with carry
      drive_alu(3'd3, 8'h5A, 3'b001, 1'b1);
      #1;
      chk("alu_ld_ready", {31'b0, ld_ready}, 32'd0);
      tick();
      idle();
      chk("pend3_set", {24'b0, pend}, 32'h08);
      chk("wr_en_lat", {31'b0, wr_en}, 32'd0);
      tick();
      chk("pend3_clr", {24'b0, pend}, 32'd0);
      chk("wr_en_seen", {31'b0, wr_en}, 32'd1);
      tick();
      chk("wr_en_drop", {31'b0, wr_en}, 32'd0);

      // load inherits flags from the preceding ALU write
      drive_alu(3'd1, 8'h11, 3'b010, 1'b1);
      tick();
      idle();
      drive_ld(3'd5, 8'hC3);
      #1;
      chk("ld_ready_free", {31'b0, ld_ready}, 32'd1);
      tick();
      idle();
      drain(6);

      // arbitration: ALU wins, load follows next cycle
      drive_alu(3'd6, 8'h66, 3'b100, 1'b1);
      ld_valid = 1'b1; ld_addr = 3'd2; ld_dat = 8'h22;
      #1;
      chk("arb_ld_ready", {31'b0, ld_ready}, 32'd0);
      tick();
      idle();
      drive_ld(3'd2, 8'h22);
      #1;
      chk("arb_ld_ready2", {31'b0, ld_ready}, 32'd1);
      tick();
      idle();
      drain(6);

      // fill under stall, then overflow drop
      wr_stall = 1'b1;
      drive_alu(3'd0, 8'hA0, 3'b001, 1'b1); tick();
      drive_alu(3'd1, 8'hA1, 3'b011, 1'b1); tick();
      drive_alu(3'd2, 8'hA2, 3'b101, 1'b1); tick();
      drive_alu(3'd4, 8'hA4, 3'b110, 1'b1); tick();
      idle();
      #1;
      chk("fill_full", {31'b0, full}, 32'd1);
      chk("fill_ld_ready", {31'b0, ld_ready}, 32'd0);
      chk("fill_pend", {24'b0, pend}, 32'h17);
      drive_alu(3'd7, 8'hEE, 3'b111, 1'b0);
      tick();
      idle();
      chk("ovf_set", {31'b0, ovf_err}, 32'd1);
      chk("ovf_full", {31'b0, full}, 32'd1);
      wr_mark = nwr;
      wr_stall = 1'b0;
      drain(10);
      chk("four_writes", nwr - wr_mark, 32'd4);
      tick();
      chk("ovf_sticky", {31'b0, ovf_err}, 32'd1);

      // async reset mid-operation discards queued entries
      wr_stall = 1'b1;
      drive_alu(3'd1, 8'hB1, 3'b000, 1'b1); tick();
      drive_alu(3'd2, 8'hB2, 3'b000, 1'b1); tick();
      drive_alu(3'd3, 8'hB3, 3'b000, 1'b1); tick();
      idle();
      wr_stall = 1'b0;
      tick();
      #2;
      reset = 1'b0;
      #1;
      chk("arst_wr_en", {31'b0, wr_en}, 32'd0);
      chk("arst_empty", {31'b0, empty}, 32'd1);
      chk("arst_pend", {24'b0, pend}, 32'd0);
      chk("arst_ovf", {31'b0, ovf_err}, 32'd0);
      sb.delete();
      sh = 3'b000;
      @(negedge clk);
      reset = 1'b1;
      wr_mark = nwr;
      for (int i = 0; i < 4; i++) tick();
      chk("arst_no_writes", nwr - wr_mark, 32'd0);

      // full queue: pop and push in the same cycle
      wr_stall = 1'b1;
      drive_alu(3'd0, 8'hC0, 3'b100, 1'b1); tick();
      drive_alu(3'd1, 8'hC1, 3'b010, 1'b1); tick();
      drive_alu(3'd2, 8'hC2, 3'b001, 1'b1); tick();
      drive_alu(3'd3, 8'hC3, 3'b011, 1'b1); tick();
      idle();
      wr_stall = 1'b0;
      #1;
      chk("pp_ld_ready_pop", {31'b0, ld_ready}, 32'd1);
      drive_alu(3'd7, 8'h77, 3'b101, 1'b1);
      #1;
      chk("pp_ld_ready_alu", {31'b0, ld_ready}, 32'd0);
      tick();
      idle();
      chk("pp_ovf", {31'b0, ovf_err}, 32'd0);
      chk("pp_full", {31'b0, full}, 32'd1);
      chk("pp_pend", {24'b0, pend}, 32'h8E);
      drive_ld(3'd6, 8'h5E);
      tick();
      idle();
      drain(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
